// File: rtl/serial_subtractor.sv
// serial_subtractor
//
// Bit-serial subtractor/adder. Two WIDTH-bit operands are latched on a start
// handshake and processed LSB-first, one bit per clock, through a single
// full-subtractor/full-adder cell with a registered borrow/carry. The result
// and final borrow/carry are published together with a one-cycle done pulse
// and held until the next operation completes.
//
// Optional feature macro: SERIAL_SUB_OVF_EN
//   defined   -> adds output ovf (signed overflow), updated together with d
//   undefined -> no ovf port and no overflow logic
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request, sampled only while busy=0
//   mode   in   0 = a-b-bin, 1 = a+b+bin (latched with start)
//   a, b   in   WIDTH-bit operands (latched with start)
//   bin    in   borrow-in / carry-in (latched with start)
//   busy   out  operation in progress
//   done   out  one-cycle pulse, d/b0 are new this cycle
//   d      out  WIDTH-bit result of the last completed operation
//   b0     out  borrow-out / carry-out of the last completed operation
//   ovf    out  signed overflow (SERIAL_SUB_OVF_EN only)

module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             b0
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;

    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic               r_mode;
    logic               r_br;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done;
    logic [WIDTH-1:0]   r_d;
    logic               r_b0;
`ifdef SERIAL_SUB_OVF_EN
    logic               r_ovf;
`endif

    logic               w_x;
    logic               w_y;
    logic               w_r;
    logic               w_brNext;
    logic               w_lastBit;
    logic               w_startAccept;
    logic               w_finish;
    logic [WIDTH-1:0]   w_word;

    // Current operand bits and the single arithmetic cell. The result bit is
    // identical for add and subtract; only the borrow/carry recurrence differs.
    always_comb begin
        w_x = r_sa[0];
        w_y = r_sb[0];
        w_r = w_x ^ w_y ^ r_br;
        if (r_mode) begin
            w_brNext = (w_x & w_y) | ((w_x ^ w_y) & r_br);
        end else begin
            w_brNext = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
        end
    end

    assign w_lastBit = (r_cnt == CNT_W'(WIDTH - 1));

    // The accumulator only needs the WIDTH-1 bits already produced: the
    // current result bit is concatenated on top to form the full word, which
    // is what gets published on the final bit. A 1-bit instance has no
    // accumulator at all.
    generate
        if (WIDTH == 1) begin : g_noAcc
            assign w_word = w_r;
        end else begin : g_acc
            logic [WIDTH-2:0] r_acc;

            assign w_word = {w_r, r_acc};

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_acc <= '0;
                end else if (r_state == SHIFT) begin
                    r_acc <= w_word[WIDTH-1:1];
                end
            end
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic. Start is only honoured in IDLE, which includes the
    // cycle in which done is high, so operations can run back-to-back.
    always_comb begin
        w_stateNext   = r_state;
        w_startAccept = 1'b0;
        w_finish      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_startAccept = 1'b1;
                    w_stateNext   = SHIFT;
                end
            end
            SHIFT: begin
                if (w_lastBit) begin
                    w_finish    = 1'b1;
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Datapath. Operands are captured once on an accepted start so input
    // changes during the operation have no effect. d/b0 change only when the
    // last bit is processed; a reset mid-operation clears everything and no
    // done pulse is produced.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa   <= '0;
            r_sb   <= '0;
            r_mode <= 1'b0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_d    <= '0;
            r_b0   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_startAccept) begin
                r_sa   <= a;
                r_sb   <= b;
                r_mode <= mode;
                r_br   <= bin;
                r_cnt  <= '0;
            end else if (r_state == SHIFT) begin
                r_sa  <= r_sa >> 1;
                r_sb  <= r_sb >> 1;
                r_br  <= w_brNext;
                r_cnt <= r_cnt + 1'b1;
                if (w_finish) begin
                    r_d    <= w_word;
                    r_b0   <= w_brNext;
                    r_done <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                    // Signed overflow: borrow/carry into the MSB differs from
                    // the borrow/carry out of it.
                    r_ovf  <= r_br ^ w_brNext;
`endif
                end
            end
        end
    end

    assign busy = (r_state == SHIFT);
    assign done = r_done;
    assign d    = r_d;
    assign b0   = r_b0;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: an 8-bit instance and a 1-bit instance
// share clock and reset. Expected results come from a plain integer model and
// are queued when a start is driven, then popped when done is observed.

module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;

    logic       start;
    logic       mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] d;
    logic       b0;

    logic       start1;
    logic       mode1;
    logic       a1;
    logic       b1;
    logic       bin1;
    logic       busy1;
    logic       done1;
    logic       d1;
    logic       b01;

`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
    logic       ovf1;
`endif

    int checks = 0;
    int errors = 0;

    // Scoreboards: {ovf, b0, d} for the 8-bit instance, {b0, d} for 1-bit.
    logic [9:0] sb8[$];
    logic [1:0] sb1[$];

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .b0    (b0)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .mode  (mode1),
        .a     (a1),
        .b     (b1),
        .bin   (bin1),
        .busy  (busy1),
        .done  (done1),
        .d     (d1),
        .b0    (b01)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf1)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: whole-word arithmetic, bit 8 is the borrow/carry.
    function automatic logic [9:0] model8(input logic [7:0] ma, input logic [7:0] mb,
                                          input logic mbin, input logic mmode);
        logic [8:0] r;
        logic       ov;
        if (mmode) begin
            r  = {1'b0, ma} + {1'b0, mb} + {8'd0, mbin};
            ov = (ma[7] == mb[7]) && (r[7] != ma[7]);
        end else begin
            r  = {1'b0, ma} - {1'b0, mb} - {8'd0, mbin};
            ov = (ma[7] != mb[7]) && (r[7] != ma[7]);
        end
        return {ov, r};
    endfunction

    // Drive a start at the current negedge; returns at the negedge after the
    // sampling edge with start low again.
    task automatic drive8(input logic [7:0] ta, input logic [7:0] tb,
                          input logic tbin, input logic tmode);
        a     = ta;
        b     = tb;
        bin   = tbin;
        mode  = tmode;
        start = 1'b1;
        sb8.push_back(model8(ta, tb, tbin, tmode));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done on the 8-bit instance. lat is the number of
    // edges after the start edge; busyCnt counts cycles busy was seen high.
    task automatic waitDone8(output int lat, output int busyCnt);
        lat     = 0;
        busyCnt = 0;
        while (!done && lat < 30) begin
            if (busy) busyCnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        logic [10:0] got8;
        logic [3:0]  got1;
        rst    = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        a = 8'h00; b = 8'h00; bin = 1'b0; mode = 1'b0;
        a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0; mode1 = 1'b0;
        repeat (3) @(negedge clk);
        got8 = {busy, done, d, b0};
        got1 = {busy1, done1, d1, b01};
        checks++;
        if (got8 !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset8 got %h expected 0", got8);
        end
        checks++;
        if (got1 !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset1 got %h expected 0", got1);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if ({ovf, ovf1} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_ovf got %b expected 00", {ovf, ovf1});
        end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Single subtraction with full timing checks.
    task automatic test_basic;
        int lat;
        int busyCnt;
        logic [9:0] exp;
        drive8(8'h35, 8'h12, 1'b0, 1'b0);
        waitDone8(lat, busyCnt);
        exp = sb8.pop_front();
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("[TB] FAIL basic_latency got %0d expected 8", lat);
        end
        checks++;
        if (busyCnt !== 8) begin
            errors++;
            $display("[TB] FAIL basic_busy_cycles got %0d expected 8", busyCnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_busy_at_done got %b expected 0", busy);
        end
        checks++;
        if ({b0, d} !== exp[8:0] || {b0, d} !== 9'h023) begin
            errors++;
            $display("[TB] FAIL basic_result got %h expected %h", {b0, d}, exp[8:0]);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || d !== 8'h23) begin
            errors++;
            $display("[TB] FAIL basic_done_pulse got done=%b d=%h expected done=0 d=23", done, d);
        end
    endtask

    // Borrow case followed by a start issued in the done cycle.
    task automatic test_back_to_back;
        int lat;
        int busyCnt;
        logic [9:0] exp;
        drive8(8'h00, 8'h01, 1'b0, 1'b0);
        waitDone8(lat, busyCnt);
        exp = sb8.pop_front();
        checks++;
        if ({b0, d} !== exp[8:0]) begin
            errors++;
            $display("[TB] FAIL b2b_first got %h expected %h", {b0, d}, exp[8:0]);
        end
        drive8(8'h10, 8'h0F, 1'b1, 1'b0);
        waitDone8(lat, busyCnt);
        exp = sb8.pop_front();
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("[TB] FAIL b2b_latency got %0d expected 8", lat);
        end
        checks++;
        if ({b0, d} !== exp[8:0]) begin
            errors++;
            $display("[TB] FAIL b2b_second got %h expected %h", {b0, d}, exp[8:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_add;
        int lat;
        int busyCnt;
        logic [9:0] exp;
        drive8(8'hFF, 8'h01, 1'b0, 1'b1);
        waitDone8(lat, busyCnt);
        exp = sb8.pop_front();
        checks++;
        if ({b0, d} !== exp[8:0]) begin
            errors++;
            $display("[TB] FAIL add_carry got %h expected %h", {b0, d}, exp[8:0]);
        end
        @(negedge clk);
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf;
        int lat;
        int busyCnt;
        logic [9:0] exp;
        drive8(8'h80, 8'h01, 1'b0, 1'b0);
        waitDone8(lat, busyCnt);
        exp = sb8.pop_front();
        checks++;
        if ({ovf, b0, d} !== exp) begin
            errors++;
            $display("[TB] FAIL ovf_sub got %h expected %h", {ovf, b0, d}, exp);
        end
        drive8(8'h7F, 8'h01, 1'b0, 1'b1);
        waitDone8(lat, busyCnt);
        exp = sb8.pop_front();
        checks++;
        if ({ovf, b0, d} !== exp) begin
            errors++;
            $display("[TB] FAIL ovf_add got %h expected %h", {ovf, b0, d}, exp);
        end
        @(negedge clk);
    endtask
`endif

    // Inputs wiggled and start pulsed while busy must be ignored.
    task automatic test_ignore_busy;
        int doneCnt;
        int doneEdge;
        logic [7:0] dSeen;
        logic [9:0] exp;
        doneCnt  = 0;
        doneEdge = -1;
        dSeen    = 8'h00;
        drive8(8'h35, 8'h12, 1'b0, 1'b0);
        exp = sb8.pop_front();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            a     = 8'($urandom);
            b     = 8'($urandom);
            bin   = 1'b1;
            mode  = ~mode;
            start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        for (int k = 6; k < 18; k++) begin
            if (done) begin
                doneCnt++;
                doneEdge = k - 1;
                dSeen    = d;
            end
            @(negedge clk);
        end
        checks++;
        if (doneCnt !== 1 || doneEdge !== 8) begin
            errors++;
            $display("[TB] FAIL ignore_done_count got %0d pulses at edge %0d expected 1 at edge 8",
                     doneCnt, doneEdge);
        end
        checks++;
        if (dSeen !== exp[7:0]) begin
            errors++;
            $display("[TB] FAIL ignore_result got %h expected %h", dSeen, exp[7:0]);
        end
        mode = 1'b0;
        bin  = 1'b0;
    endtask

    // Reset at edge 4 aborts the operation; a later start works normally.
    task automatic test_reset_mid;
        int doneCnt;
        int lat;
        int busyCnt;
        logic [9:0] exp;
        drive8(8'hA5, 8'h3C, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, d, b0} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset got busy=%b done=%b d=%h b0=%b expected all 0",
                     busy, done, d, b0);
        end
        rst = 1'b0;
        void'(sb8.pop_front());
        doneCnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        checks++;
        if (doneCnt !== 0) begin
            errors++;
            $display("[TB] FAIL mid_reset_no_done got %0d pulses expected 0", doneCnt);
        end
        drive8(8'h5A, 8'h21, 1'b1, 1'b0);
        waitDone8(lat, busyCnt);
        exp = sb8.pop_front();
        checks++;
        if (lat !== 8 || {b0, d} !== exp[8:0]) begin
            errors++;
            $display("[TB] FAIL mid_reset_restart got lat=%0d res=%h expected lat=8 res=%h",
                     lat, {b0, d}, exp[8:0]);
        end
        @(negedge clk);
    endtask

    // Random operations chained back-to-back in the done cycle.
    task automatic test_random;
        int lat;
        int busyCnt;
        logic [9:0] exp;
        drive8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        for (int i = 0; i < 8; i++) begin
            waitDone8(lat, busyCnt);
            exp = sb8.pop_front();
            checks++;
            if (lat !== 8 || {b0, d} !== exp[8:0]) begin
                errors++;
                $display("[TB] FAIL random_%0d got lat=%0d res=%h expected lat=8 res=%h",
                         i, lat, {b0, d}, exp[8:0]);
            end
            if (i < 7) begin
                drive8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            end
        end
        @(negedge clk);
    endtask

    // 1-bit instance: full-subtractor truth table, done one clock after start.
    task automatic test_width1;
        int lat;
        logic [1:0] exp;
        logic [1:0] diff;
        for (int c = 0; c < 8; c++) begin
            a1     = c[2];
            b1     = c[1];
            bin1   = c[0];
            mode1  = 1'b0;
            start1 = 1'b1;
            diff   = {1'b0, a1} - {1'b0, b1} - {1'b0, bin1};
            sb1.push_back(diff);
            @(negedge clk);
            start1 = 1'b0;
            lat    = 0;
            while (!done1 && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            exp = sb1.pop_front();
            checks++;
            if (lat !== 1 || {b01, d1} !== exp) begin
                errors++;
                $display("[TB] FAIL width1_%0d got lat=%0d b0d=%b expected lat=1 b0d=%b",
                         c, lat, {b01, d1}, exp);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_add();
`ifdef SERIAL_SUB_OVF_EN
        test_ovf();
`endif
        test_ignore_busy();
        test_reset_mid();
        test_random();
        test_width1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
